// File: rtl/inst_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// inst_buffer_ctrl
//   Pointer/occupancy controller for the decoded-instruction FIFO that sits
//   between decode and rename. The FIFO storage itself is an external
//   multiported SRAM (FETCH_WIDTH write ports, DISPATCH_WIDTH read ports);
//   this block only produces its enables and addresses.
//   - Compacts a sparse decoded group into consecutive FIFO entries.
//   - Presents DISPATCH_WIDTH read addresses starting at the head.
//   - Owns fetch back-pressure, the dispatch handshake and flush recovery.
//
// Optional feature macro: INSTBUF_PARTIAL_DISPATCH_EN
//   When defined, a partial group (1..DISPATCH_WIDTH-1 entries) is dispatched
//   after STARVE_CYCLES consecutive idle cycles. When undefined, only full
//   groups of DISPATCH_WIDTH are ever dispatched.
//
// Ports
//   clk               in   clock, all state on posedge
//   reset_n           in   asynchronous active-low reset
//   flush_i           in   misprediction flush (synchronous, beats all updates)
//   stall_i           in   rename-side back-pressure (only gates consumption)
//   decodeReady_i     in   decode group valid this cycle
//   decodedVector_i   in   per-slot valid, may be sparse
//   stallFetch_o      out  fetch must hold (queue cannot take a whole group)
//   writeEnable_o     out  SRAM write enable per slot
//   writeAddr_o       out  SRAM write address per slot, slot k at [k*QUEUE_LOG +: QUEUE_LOG]
//   readAddr_o        out  head, head+1, ... (mod depth), one per read port
//   instBufferReady_o out  dispatch group valid
//   dispatchCount_o   out  instructions in the presented group
//   instCount_o       out  current occupancy
// ---------------------------------------------------------------------------
module inst_buffer_ctrl #(
  parameter int QUEUE_DEPTH    = 32,
  parameter int QUEUE_LOG      = 5,
  parameter int FETCH_WIDTH    = 8,
  parameter int DISPATCH_WIDTH = 4,
  parameter int STARVE_CYCLES  = 4
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                flush_i,
  input  logic                                stall_i,
  input  logic                                decodeReady_i,
  input  logic [FETCH_WIDTH-1:0]              decodedVector_i,
  output logic                                stallFetch_o,
  output logic [FETCH_WIDTH-1:0]              writeEnable_o,
  output logic [FETCH_WIDTH*QUEUE_LOG-1:0]    writeAddr_o,
  output logic [DISPATCH_WIDTH*QUEUE_LOG-1:0] readAddr_o,
  output logic                                instBufferReady_o,
  output logic [QUEUE_LOG:0]                  dispatchCount_o,
  output logic [QUEUE_LOG:0]                  instCount_o
);

  localparam logic [2:0] ST_EMPTY   = 3'd0;
  localparam logic [2:0] ST_PARTIAL = 3'd1;
  localparam logic [2:0] ST_READY   = 3'd2;
  localparam logic [2:0] ST_FULL    = 3'd3;
  localparam logic [2:0] ST_FLUSHED = 3'd4;

  localparam logic [QUEUE_LOG:0]   C_CNT_ZERO = {(QUEUE_LOG+1){1'b0}};
  localparam logic [QUEUE_LOG:0]   C_DW       = (QUEUE_LOG+1)'(DISPATCH_WIDTH);
  // Above this occupancy a whole fetch group might not fit any more.
  localparam logic [QUEUE_LOG:0]   C_FULL_TH  = (QUEUE_LOG+1)'(QUEUE_DEPTH - FETCH_WIDTH);
  localparam logic [QUEUE_LOG-1:0] C_PTR_ZERO = {QUEUE_LOG{1'b0}};

  // Number of set bits in a slot vector, widened to occupancy width.
  function automatic logic [QUEUE_LOG:0] f_popcount(input logic [FETCH_WIDTH-1:0] v);
    logic [QUEUE_LOG:0] c;
    c = {(QUEUE_LOG+1){1'b0}};
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      c = c + {{QUEUE_LOG{1'b0}}, v[i]};
    end
    return c;
  endfunction

  logic [QUEUE_LOG-1:0]           r_head;
  logic [QUEUE_LOG-1:0]           r_tail;
  logic [QUEUE_LOG:0]             r_count;
  logic [2:0]                     r_state;

  logic                           w_full;
  logic                           w_accept;
  logic [FETCH_WIDTH-1:0]         w_wr_en;
  logic [QUEUE_LOG:0]             w_run;
  logic [FETCH_WIDTH*QUEUE_LOG-1:0] w_wr_addr;
  logic [DISPATCH_WIDTH*QUEUE_LOG-1:0] w_rd_addr;
  logic [QUEUE_LOG:0]             w_nwr;
  logic                           w_grp_ready;
  logic                           w_part_ready;
  logic                           w_ready;
  logic [QUEUE_LOG:0]             w_disp_cnt;
  logic [QUEUE_LOG:0]             w_ndisp;
  logic [QUEUE_LOG:0]             w_count_nxt;
  logic [2:0]                     w_state_nxt;

  // Full is derived straight from the occupancy register so back-pressure
  // never depends on this cycle's inputs.
  assign w_full   = (r_count > C_FULL_TH);
  assign w_accept = decodeReady_i & ~w_full & ~flush_i;
  assign w_wr_en  = {FETCH_WIDTH{w_accept}} & decodedVector_i;
  assign w_nwr    = f_popcount(w_wr_en);

  // Compaction: slot k lands at tail + (valid slots below k). Addresses are
  // computed from the raw vector so idle slots still get a stable value.
  always_comb begin
    w_run     = {(QUEUE_LOG+1){1'b0}};
    w_wr_addr = {(FETCH_WIDTH*QUEUE_LOG){1'b0}};
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      w_wr_addr[k*QUEUE_LOG +: QUEUE_LOG] = r_tail + w_run[QUEUE_LOG-1:0];
      w_run = w_run + {{QUEUE_LOG{1'b0}}, decodedVector_i[k]};
    end
  end

  // Read ports look at consecutive entries from the head, wrapping naturally.
  always_comb begin
    w_rd_addr = {(DISPATCH_WIDTH*QUEUE_LOG){1'b0}};
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      w_rd_addr[k*QUEUE_LOG +: QUEUE_LOG] = r_head + QUEUE_LOG'(k);
    end
  end

  assign w_grp_ready = (r_count >= C_DW) & ~flush_i & (r_state != ST_FLUSHED);

`ifdef INSTBUF_PARTIAL_DISPATCH_EN
  localparam int                C_SW          = $clog2(STARVE_CYCLES + 1);
  localparam logic [C_SW-1:0]   C_STARVE      = C_SW'(STARVE_CYCLES);
  localparam logic [C_SW-1:0]   C_STARVE_ZERO = {C_SW{1'b0}};
  localparam logic [C_SW-1:0]   C_STARVE_ONE  = C_SW'(1);

  logic [C_SW-1:0] r_starve;

  // Starvation counter: counts idle PARTIAL cycles, saturates at the limit,
  // restarts on any queue activity.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve <= C_STARVE_ZERO;
    end else if (flush_i || (w_nwr != C_CNT_ZERO) || (w_ndisp != C_CNT_ZERO)) begin
      r_starve <= C_STARVE_ZERO;
    end else if ((r_state == ST_PARTIAL) && (r_starve != C_STARVE)) begin
      r_starve <= r_starve + C_STARVE_ONE;
    end else begin
      r_starve <= r_starve;
    end
  end

  assign w_part_ready = (r_state == ST_PARTIAL) & (r_starve == C_STARVE) & ~flush_i;
`else
  // Partial groups never dispatch in this build; the comparison is
  // constant-false for any legal STARVE_CYCLES.
  assign w_part_ready = (STARVE_CYCLES < 32'sd0);
`endif

  // Dispatch group selection: full group first, starved partial group second.
  always_comb begin
    w_ready    = 1'b0;
    w_disp_cnt = C_CNT_ZERO;
    if (w_grp_ready) begin
      w_ready    = 1'b1;
      w_disp_cnt = C_DW;
    end else if (w_part_ready) begin
      w_ready    = 1'b1;
      w_disp_cnt = r_count;
    end else begin
      w_ready    = 1'b0;
      w_disp_cnt = C_CNT_ZERO;
    end
  end

  // stall_i only decides consumption; it never reaches an output.
  assign w_ndisp     = (w_ready & ~stall_i) ? w_disp_cnt : C_CNT_ZERO;
  assign w_count_nxt = r_count + w_nwr - w_ndisp;

  // Next state classifies the next occupancy.
  always_comb begin
    w_state_nxt = ST_EMPTY;
    if (w_count_nxt == C_CNT_ZERO) begin
      w_state_nxt = ST_EMPTY;
    end else if (w_count_nxt > C_FULL_TH) begin
      w_state_nxt = ST_FULL;
    end else if (w_count_nxt >= C_DW) begin
      w_state_nxt = ST_READY;
    end else begin
      w_state_nxt = ST_PARTIAL;
    end
  end

  // Pointer, occupancy and state registers; flush wins over normal updates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= C_PTR_ZERO;
      r_tail  <= C_PTR_ZERO;
      r_count <= C_CNT_ZERO;
      r_state <= ST_EMPTY;
    end else if (flush_i) begin
      r_head  <= C_PTR_ZERO;
      r_tail  <= C_PTR_ZERO;
      r_count <= C_CNT_ZERO;
      r_state <= ST_FLUSHED;
    end else begin
      r_head  <= r_head + w_ndisp[QUEUE_LOG-1:0];
      r_tail  <= r_tail + w_nwr[QUEUE_LOG-1:0];
      r_count <= w_count_nxt;
      r_state <= w_state_nxt;
    end
  end

  assign stallFetch_o      = w_full;
  assign writeEnable_o     = w_wr_en;
  assign writeAddr_o       = w_wr_addr;
  assign readAddr_o        = w_rd_addr;
  assign instBufferReady_o = w_ready;
  assign dispatchCount_o   = w_disp_cnt;
  assign instCount_o       = r_count;

endmodule

// File: tb/tb_inst_buffer_ctrl.sv
// Directed self-checking bench for inst_buffer_ctrl (default parameters).
module tb_inst_buffer_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush_i;
  logic        stall_i;
  logic        decodeReady_i;
  logic [7:0]  decodedVector_i;
  logic        stallFetch_o;
  logic [7:0]  writeEnable_o;
  logic [39:0] writeAddr_o;
  logic [19:0] readAddr_o;
  logic        instBufferReady_o;
  logic [5:0]  dispatchCount_o;
  logic [5:0]  instCount_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_buffer_ctrl dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .flush_i           (flush_i),
    .stall_i           (stall_i),
    .decodeReady_i     (decodeReady_i),
    .decodedVector_i   (decodedVector_i),
    .stallFetch_o      (stallFetch_o),
    .writeEnable_o     (writeEnable_o),
    .writeAddr_o       (writeAddr_o),
    .readAddr_o        (readAddr_o),
    .instBufferReady_o (instBufferReady_o),
    .dispatchCount_o   (dispatchCount_o),
    .instCount_o       (instCount_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle a little after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] waddr(input int k);
    return writeAddr_o[k*5 +: 5];
  endfunction

  function automatic logic [4:0] raddr(input int k);
    return readAddr_o[k*5 +: 5];
  endfunction

  logic [39:0] exp_wa;

  initial begin
    reset_n = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
    decodeReady_i = 1'b0; decodedVector_i = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count",   64'(instCount_o),       64'd0);
    chk("rst_stallF",  64'(stallFetch_o),      64'd0);
    chk("rst_ready",   64'(instBufferReady_o), 64'd0);
    chk("rst_dcount",  64'(dispatchCount_o),   64'd0);
    chk("rst_we",      64'(writeEnable_o),     64'd0);
    #2 reset_n = 1'b1;

    // Full group from empty: addresses 0..7, stalled rename.
    decodeReady_i = 1'b1; decodedVector_i = 8'hFF; stall_i = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) exp_wa[k*5 +: 5] = 5'(k);
    chk("g1_we",    64'(writeEnable_o), 64'hFF);
    chk("g1_waddr", 64'(writeAddr_o),   64'(exp_wa));
    step();
    decodeReady_i = 1'b0;
    #1;
    chk("g1_count",  64'(instCount_o),       64'd8);
    chk("g1_ready",  64'(instBufferReady_o), 64'd1);
    chk("g1_dcount", 64'(dispatchCount_o),   64'd4);
    chk("g1_raddr",  64'(readAddr_o),        64'({5'd3, 5'd2, 5'd1, 5'd0}));
    chk("g1_tail",   64'(waddr(0)),          64'd8);
    chk("g1_state",  64'(dut.r_state),       64'd2);

    // Two more groups: count 24 is the last non-full occupancy.
    decodeReady_i = 1'b1; decodedVector_i = 8'hFF;
    step(); step();
    decodeReady_i = 1'b0;
    #1;
    chk("c24_count",  64'(instCount_o),  64'd24);
    chk("c24_stallF", 64'(stallFetch_o), 64'd0);

    // Drain four groups: count 8, head 16.
    stall_i = 1'b0;
    repeat (4) step();
    stall_i = 1'b1;
    chk("drain_count", 64'(instCount_o), 64'd8);
    chk("drain_head",  64'(raddr(0)),    64'd16);

    // Six entries move the tail to 30.
    decodeReady_i = 1'b1; decodedVector_i = 8'h3F;
    step();
    decodeReady_i = 1'b0;
    #1;
    chk("t30_count", 64'(instCount_o), 64'd14);
    chk("t30_tail",  64'(waddr(0)),    64'd30);

    // Sparse vector across the wrap point.
    decodeReady_i = 1'b1; decodedVector_i = 8'b1010_0101;
    #1;
    chk("sp_we",    64'(writeEnable_o), 64'hA5);
    chk("sp_waddr", 64'(writeAddr_o),
        64'({5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd30}));
    step();
    decodeReady_i = 1'b0;
    #1;
    chk("sp_count", 64'(instCount_o), 64'd18);
    chk("sp_tail",  64'(waddr(0)),    64'd2);

    // Reach 25 entries: full, further groups are refused.
    decodeReady_i = 1'b1; decodedVector_i = 8'h7F;
    step();
    decodedVector_i = 8'hFF;
    #1;
    chk("full_count",  64'(instCount_o),  64'd25);
    chk("full_stallF", 64'(stallFetch_o), 64'd1);
    chk("full_we",     64'(writeEnable_o), 64'd0);
    chk("full_state",  64'(dut.r_state),  64'd3);
    step();
    chk("full_hold",   64'(instCount_o),  64'd25);
    stall_i = 1'b0; decodeReady_i = 1'b0;
    step();
    chk("rel_count",  64'(instCount_o),  64'd21);
    chk("rel_stallF", 64'(stallFetch_o), 64'd0);
    chk("rel_head",   64'(raddr(0)),     64'd20);

    // 21 -> 17 -> 13, then one write plus one dispatch -> 10.
    step(); step();
    decodeReady_i = 1'b1; decodedVector_i = 8'h01;
    step();
    chk("c10_count", 64'(instCount_o), 64'd10);
    chk("c10_head",  64'(raddr(0)),    64'd0);
    chk("c10_tail",  64'(waddr(0)),    64'd10);

    // Simultaneous write of 8 and dispatch of 4.
    decodedVector_i = 8'hFF;
    #1;
    chk("wd_we",    64'(writeEnable_o),     64'hFF);
    chk("wd_ready", 64'(instBufferReady_o), 64'd1);
    step();
    decodeReady_i = 1'b0;
    #1;
    chk("wd_count", 64'(instCount_o), 64'd14);
    chk("wd_head",  64'(raddr(0)),    64'd4);
    chk("wd_tail",  64'(waddr(0)),    64'd18);

    // Count 12, then flush with a write pending.
    decodeReady_i = 1'b1; decodedVector_i = 8'h03;
    step();
    chk("pf_count", 64'(instCount_o), 64'd12);
    flush_i = 1'b1; decodedVector_i = 8'hFF;
    #1;
    chk("fl_we",     64'(writeEnable_o),     64'd0);
    chk("fl_ready",  64'(instBufferReady_o), 64'd0);
    chk("fl_dcount", 64'(dispatchCount_o),   64'd0);
    step();
    flush_i = 1'b0; decodeReady_i = 1'b0;
    #1;
    chk("fl_count", 64'(instCount_o), 64'd0);
    chk("fl_head",  64'(raddr(0)),    64'd0);
    chk("fl_tail",  64'(waddr(0)),    64'd0);
    chk("fl_state", 64'(dut.r_state), 64'd4);
    step();
    chk("fl_empty", 64'(dut.r_state), 64'd0);

    // Two entries, then idle cycles.
    decodeReady_i = 1'b1; decodedVector_i = 8'h03;
    step();
    decodeReady_i = 1'b0;
    #1;
    chk("pt_count", 64'(instCount_o),       64'd2);
    chk("pt_ready", 64'(instBufferReady_o), 64'd0);
    repeat (4) step();
`ifdef INSTBUF_PARTIAL_DISPATCH_EN
    chk("pt_sready", 64'(instBufferReady_o), 64'd1);
    chk("pt_sdc",    64'(dispatchCount_o),   64'd2);
    step();
    chk("pt_drain",  64'(instCount_o),       64'd0);
`else
    chk("pt_wait_ready", 64'(instBufferReady_o), 64'd0);
    chk("pt_wait_dc",    64'(dispatchCount_o),   64'd0);
    repeat (2) step();
    chk("pt_hold_ready", 64'(instBufferReady_o), 64'd0);
    chk("pt_hold_count", 64'(instCount_o),       64'd2);
`endif

    // Asynchronous reset in the middle of a cycle.
    decodeReady_i = 1'b1; decodedVector_i = 8'h0F; stall_i = 1'b1;
    step();
    decodeReady_i = 1'b0;
    #1;
    chk("ar_pre_ready", 64'(instBufferReady_o), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("ar_count", 64'(instCount_o),       64'd0);
    chk("ar_ready", 64'(instBufferReady_o), 64'd0);
    chk("ar_head",  64'(raddr(0)),          64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
